// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Instruction queue between the IF and ID stages. It is a DEPTH-entry ring
// buffer followed by a registered output stage that feeds ID. Fetch can keep
// pushing while ID is stalled, up to DEPTH queued instructions plus the one
// held in the output register.
//
// When there is no real instruction to present (empty queue or flush), the
// output register shows pc=0, inst=0 with valid_out=0.
//
// Ports:
//   clk_in        clock
//   rst_in        synchronous active-high reset
//   rdy_in        global ready; when low every register holds
//   flush_in      redirect; discards the queue and the output register
//   stall_in      ID stall; output register holds, pushes still accepted
//   instE_in      IF push request
//   pc_in         PC of the pushed instruction
//   inst_in       pushed instruction
//   full_out      queue holds DEPTH entries; IF must not push
//   IF_ID_pc_out  registered PC to ID
//   inst_out      registered instruction to ID
//   valid_out     output register holds a real instruction
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  stall_in,
    input  logic                  instE_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic                  full_out,
    output logic [ADDR_WIDTH-1:0] IF_ID_pc_out,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  valid_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic empty;
    logic push_ok;
    logic write_en;

    // full_out depends on count alone, so IF never sees a combinational
    // path from stall_in or instE_in back to itself.
    assign full_out = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign push_ok  = instE_in && !full_out;

    // An accepted push goes into storage unless it bypasses straight into
    // the output register, which only happens when advancing from empty.
    assign write_en = !rst_in && rdy_in && !flush_in && push_ok
                      && (stall_in || !empty);

    // Storage has no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk_in) begin
        if (write_en) begin
            pc_mem[tail]   <= pc_in;
            inst_mem[tail] <= inst_in;
        end
    end

    // Pointers, count and output register. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            IF_ID_pc_out <= '0;
            inst_out     <= '0;
            valid_out    <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                IF_ID_pc_out <= '0;
                inst_out     <= '0;
                valid_out    <= 1'b0;
            end else if (!stall_in) begin
                if (!empty) begin
                    IF_ID_pc_out <= pc_mem[head];
                    inst_out     <= inst_mem[head];
                    valid_out    <= 1'b1;
                    head         <= head + PTR_ONE;
                    // A simultaneous push and pop leaves count unchanged.
                    if (push_ok) begin
                        tail <= tail + PTR_ONE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end else if (push_ok) begin
                    IF_ID_pc_out <= pc_in;
                    inst_out     <= inst_in;
                    valid_out    <= 1'b1;
                end else begin
                    IF_ID_pc_out <= '0;
                    inst_out     <= '0;
                    valid_out    <= 1'b0;
                end
            end else if (push_ok) begin
                tail  <= tail + PTR_ONE;
                count <= count + CNT_ONE;
            end
        end
    end

endmodule
